// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
//
// Duty-cycle sequencer for the 8-bit PWM generator. The host hands over a
// target duty with a valid/ready handshake. The block then ramps its registered
// duty output toward that target by STEP counts once every PERIODS_PER_STEP PWM
// periods. This gives the load a soft start and a soft stop. The duty output
// feeds the PWM comparator directly.
//
// Parameters
//   STEP              duty increment/decrement per ramp step (1..255)
//   PERIODS_PER_STEP  PWM periods between ramp steps         (1..255)
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous reset, ACTIVE-HIGH (1 resets on next edge)
//   ena           in   block enable; 0 freezes all state
//   period_tick   in   one-cycle pulse per PWM period, from the prescaler
//   target[7:0]   in   requested duty
//   target_valid  in   target presented
//   target_ready  out  combinational; target accepted when valid & ready
//   duty[7:0]     out  current duty, registered
//   busy          out  1 while ramping (state UP or DOWN)
//   done          out  one-cycle pulse when duty reaches target
//   stop          in   (PWM_RAMP_STOP_EN only) level; ramps the duty to 0
//
// Build option
//   PWM_RAMP_STOP_EN  when defined, adds the stop input. While stop=1 and
//                     ena=1, the block ramps down to 0 and refuses new targets.
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl #(
  parameter int unsigned STEP             = 1,
  parameter int unsigned PERIODS_PER_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       period_tick,
  input  logic [7:0] target,
  input  logic       target_valid,
`ifdef PWM_RAMP_STOP_EN
  input  logic       stop,
`endif
  output logic       target_ready,
  output logic [7:0] duty,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  localparam logic [7:0] STEP8  = 8'(STEP);
  localparam logic [8:0] STEP9  = 9'(STEP);
  localparam logic [7:0] PPS_M1 = 8'(PERIODS_PER_STEP - 1);

  state_e     state_q, state_d;
  logic [7:0] duty_q,  duty_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [7:0] tgt_q,   tgt_d;
  logic       done_q,  done_d;

  logic       stop_act;
  logic       accept;
  logic       tick_en;
  logic       step_ev;
  logic [7:0] eff_tgt;
  logic [8:0] up_diff;
  logic [8:0] dn_diff;

  // An active stop behaves as a forced target of 0. It only counts while the
  // block is enabled.
`ifdef PWM_RAMP_STOP_EN
  assign stop_act = ena & stop;
`else
  assign stop_act = 1'b0;
`endif

  // rst_n is active-high despite its name. Ready is masked while it is
  // asserted, so a target presented during reset is never taken.
  assign target_ready = ena & (state_q == ST_IDLE) & ~rst_n & ~stop_act;
  assign accept       = target_valid & target_ready;

  assign tick_en = ena & period_tick;
  assign step_ev = tick_en & (cnt_q == PPS_M1);

  assign eff_tgt = stop_act ? 8'd0 : tgt_q;

  // The distances are 9 bits wide. The "last step" test therefore sees the
  // true gap, and duty can never overshoot or wrap.
  assign up_diff = {1'b0, eff_tgt} - {1'b0, duty_q};
  assign dn_diff = {1'b0, duty_q}  - {1'b0, eff_tgt};

  always_comb begin
    // NOTE: every variable gets a default before any branch. This stops an
    // incomplete if/case from inferring a latch.
    state_d = state_q;
    duty_d  = duty_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;

    if (ena) begin
      unique case (state_q)
        ST_IDLE: begin
          if (stop_act) begin
            if (duty_q != 8'd0) begin
              state_d = ST_DOWN;
              cnt_d   = 8'd0;
            end
          end else if (accept) begin
            // A period_tick in this cycle is deliberately not counted.
            tgt_d = target;
            cnt_d = 8'd0;
            if (target > duty_q) begin
              state_d = ST_UP;
            end else if (target < duty_q) begin
              state_d = ST_DOWN;
            end else begin
              done_d = 1'b1;
            end
          end
        end

        ST_UP: begin
          if (stop_act) begin
            state_d = ST_DOWN;
            cnt_d   = 8'd0;
          end else if (tick_en) begin
            if (step_ev) begin
              cnt_d = 8'd0;
              if (up_diff <= STEP9) begin
                duty_d  = eff_tgt;
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                duty_d = duty_q + STEP8;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end

        ST_DOWN: begin
          // A stop that arrives mid-descent keeps the step counter running.
          // Only the goal moves to 0.
          if (tick_en) begin
            if (step_ev) begin
              cnt_d = 8'd0;
              if (dn_diff <= STEP9) begin
                duty_d  = eff_tgt;
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                duty_d = duty_q - STEP8;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (stop_act) begin
        tgt_d = 8'd0;
      end
    end
  end

  // One register block holds the whole FSM and its datapath. Reset is
  // synchronous and active-high on rst_n.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only. Every flop
      // then samples the pre-edge values, whatever order the statements are in.
      state_q <= ST_IDLE;
      duty_q  <= 8'd0;
      cnt_q   <= 8'd0;
      tgt_q   <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  assign duty = duty_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
//
// Instances:
//   u_def  default parameters (STEP=1, PERIODS_PER_STEP=4)
//   u_s16  STEP=16, PERIODS_PER_STEP=1, driven by a vector table
//   u_stp  STEP=1, PERIODS_PER_STEP=1, with the stop port (PWM_RAMP_STOP_EN)
//
// All instances share one set of inputs. Each test sequence starts from reset.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       period_tick = 1'b0;
  logic [7:0] target = 8'd0;
  logic       target_valid = 1'b0;

  logic       d_ready, d_busy, d_done;
  logic [7:0] d_duty;
  logic       s_ready, s_busy, s_done;
  logic [7:0] s_duty;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl u_def (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .period_tick  (period_tick),
    .target       (target),
    .target_valid (target_valid),
`ifdef PWM_RAMP_STOP_EN
    .stop         (1'b0),
`endif
    .target_ready (d_ready),
    .duty         (d_duty),
    .busy         (d_busy),
    .done         (d_done)
  );

  pwm_ramp_ctrl #(.STEP(16), .PERIODS_PER_STEP(1)) u_s16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .period_tick  (period_tick),
    .target       (target),
    .target_valid (target_valid),
`ifdef PWM_RAMP_STOP_EN
    .stop         (1'b0),
`endif
    .target_ready (s_ready),
    .duty         (s_duty),
    .busy         (s_busy),
    .done         (s_done)
  );

`ifdef PWM_RAMP_STOP_EN
  logic       stop = 1'b0;
  logic       p_ready, p_busy, p_done;
  logic [7:0] p_duty;

  pwm_ramp_ctrl #(.STEP(1), .PERIODS_PER_STEP(1)) u_stp (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .period_tick  (period_tick),
    .target       (target),
    .target_valid (target_valid),
    .stop         (stop),
    .target_ready (p_ready),
    .duty         (p_duty),
    .busy         (p_busy),
    .done         (p_done)
  );
`endif

  typedef struct {
    logic       rst;
    logic       en;
    logic       tick;
    logic       vld;
    logic [7:0] tgt;
    logic       x_ready;   // expected during the cycle, before the edge
    logic [7:0] x_duty;    // expected just after the edge
    logic       x_busy;
    logic       x_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic t,
                              input logic v, input logic [7:0] tg,
                              input logic xr, input logic [7:0] xd,
                              input logic xb, input logic xdn);
    vec_t x;
    x.rst = r; x.en = e; x.tick = t; x.vld = v; x.tgt = tg;
    x.x_ready = xr; x.x_duty = xd; x.x_busy = xb; x.x_done = xdn;
    vecs.push_back(x);
  endfunction

  // Inputs change on the falling edge. The #1 lets combinational ready settle.
  task automatic drive(input logic r, input logic e, input logic t,
                       input logic v, input logic [7:0] tg);
    @(negedge clk);
    rst_n        = r;
    ena          = e;
    period_tick  = t;
    target_valid = v;
    target       = tg;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- vector table for u_s16 (STEP=16, PPS=1) ----------------
    // fields: rst en tick vld tgt | ready duty busy done
    add(1,0,0,0,8'd0,   0,8'd0,  0,0);   // reset
    add(0,1,0,1,8'd40,  1,8'd0,  1,0);   // accept 40
    add(0,1,1,0,8'd0,   0,8'd16, 1,0);
    add(0,1,1,0,8'd0,   0,8'd32, 1,0);
    add(0,1,1,0,8'd0,   0,8'd40, 0,1);   // clamp to 40, no overshoot
    add(0,1,0,0,8'd0,   1,8'd40, 0,0);
    add(0,1,1,1,8'd5,   1,8'd40, 1,0);   // tick in the accept cycle is ignored
    add(0,1,1,0,8'd0,   0,8'd24, 1,0);
    add(0,1,1,0,8'd0,   0,8'd8,  1,0);
    add(0,1,1,0,8'd0,   0,8'd5,  0,1);   // clamp to 5, no wrap
    add(0,1,0,1,8'd250, 1,8'd5,  1,0);   // ramp up to 250
    for (int k = 1; k <= 15; k++) add(0,1,1,0,8'd0, 0,8'(5 + 16*k), 1,0);
    add(0,1,1,0,8'd0,   0,8'd250,0,1);
    add(0,1,0,1,8'd255, 1,8'd250,1,0);   // 250 -> 255 in one step
    add(0,1,1,0,8'd0,   0,8'd255,0,1);
    add(0,1,0,1,8'd10,  1,8'd255,1,0);   // ramp down to 10
    for (int k = 1; k <= 15; k++) add(0,1,1,0,8'd0, 0,8'(255 - 16*k), 1,0);
    add(0,1,1,0,8'd0,   0,8'd10, 0,1);
    add(0,1,0,1,8'd0,   1,8'd10, 1,0);   // 10 -> 0 in one step
    add(0,1,1,0,8'd0,   0,8'd0,  0,1);
    add(0,1,0,1,8'd0,   1,8'd0,  0,1);   // zero-length accept
    add(0,1,0,0,8'd0,   1,8'd0,  0,0);
    add(0,1,0,1,8'd32,  1,8'd0,  1,0);   // accept 32
    add(0,1,0,1,8'd48,  0,8'd0,  1,0);   // 48 held off during UP
    add(0,1,1,1,8'd48,  0,8'd16, 1,0);
    add(0,1,1,1,8'd48,  0,8'd32, 0,1);
    add(0,1,0,1,8'd48,  1,8'd32, 1,0);   // 48 accepted once IDLE
    add(0,1,1,0,8'd0,   0,8'd48, 0,1);
    add(0,0,1,1,8'd99,  0,8'd48, 0,0);   // ena=0: no accept, no tick

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].tick, vecs[i].vld, vecs[i].tgt);
      check($sformatf("v%0d ready", i), int'(s_ready), int'(vecs[i].x_ready));
      edge_wait();
      check($sformatf("v%0d duty", i), int'(s_duty), int'(vecs[i].x_duty));
      check($sformatf("v%0d busy", i), int'(s_busy), int'(vecs[i].x_busy));
      check($sformatf("v%0d done", i), int'(s_done), int'(vecs[i].x_done));
    end

    // ---------------- u_def: soft start to 3, one step per 4 ticks ----------
    drive(1,0,0,0,8'd0);
    edge_wait();
    check("t1 reset duty", int'(d_duty), 0);
    check("t1 reset busy", int'(d_busy), 0);
    check("t1 reset done", int'(d_done), 0);
    drive(0,1,0,1,8'd3);
    check("t1 ready at accept", int'(d_ready), 1);
    edge_wait();
    check("t1 busy after accept", int'(d_busy), 1);
    for (int n = 1; n <= 12; n++) begin
      drive(0,1,1,0,8'd0);
      edge_wait();
      check($sformatf("t1 duty tick%0d", n), int'(d_duty), n / 4);
      check($sformatf("t1 done tick%0d", n), int'(d_done), (n == 12) ? 1 : 0);
      check($sformatf("t1 busy tick%0d", n), int'(d_busy), (n == 12) ? 0 : 1);
      for (int g = 0; g < 4; g++) begin
        drive(0,1,0,0,8'd0);
        edge_wait();
      end
    end
    check("t1 done cleared", int'(d_done), 0);
    check("t1 busy low", int'(d_busy), 0);
    check("t1 duty final", int'(d_duty), 3);

    // ---------------- u_def: freeze with ena=0, then reset mid-ramp ----------
    drive(1,1,0,0,8'd0);
    edge_wait();
    drive(0,1,0,1,8'd8);
    edge_wait();
    for (int n = 1; n <= 8; n++) begin
      drive(0,1,1,0,8'd0);
      edge_wait();
    end
    check("t5 duty before freeze", int'(d_duty), 2);
    for (int n = 0; n < 20; n++) begin
      drive(0,0,1,0,8'd0);
      check($sformatf("t5 ready frozen%0d", n), int'(d_ready), 0);
      edge_wait();
      check($sformatf("t5 duty frozen%0d", n), int'(d_duty), 2);
    end
    check("t5 busy frozen", int'(d_busy), 1);
    for (int n = 1; n <= 4; n++) begin
      drive(0,1,1,0,8'd0);
      edge_wait();
      check($sformatf("t5 resume tick%0d", n), int'(d_duty), (n == 4) ? 3 : 2);
    end
    drive(1,1,1,0,8'd0);
    edge_wait();
    check("t5 reset duty", int'(d_duty), 0);
    check("t5 reset busy", int'(d_busy), 0);
    drive(0,1,0,0,8'd0);
    check("t5 ready after reset", int'(d_ready), 1);
    edge_wait();

`ifdef PWM_RAMP_STOP_EN
    // ---------------- u_stp: stop while ramping up ----------------------------
    drive(1,1,0,0,8'd0);
    edge_wait();
    drive(0,1,0,1,8'd9);
    edge_wait();
    for (int n = 1; n <= 5; n++) begin
      drive(0,1,1,0,8'd0);
      edge_wait();
    end
    check("t6 duty before stop", int'(p_duty), 5);
    stop = 1'b1;
    drive(0,1,0,0,8'd0);
    check("t6 ready under stop", int'(p_ready), 0);
    edge_wait();
    check("t6 busy in DOWN", int'(p_busy), 1);
    check("t6 duty held", int'(p_duty), 5);
    for (int n = 1; n <= 5; n++) begin
      drive(0,1,1,0,8'd0);
      edge_wait();
      check($sformatf("t6 duty down%0d", n), int'(p_duty), 5 - n);
      check($sformatf("t6 done down%0d", n), int'(p_done), (n == 5) ? 1 : 0);
    end
    drive(0,1,0,1,8'd7);
    check("t6 ready with valid and stop", int'(p_ready), 0);
    edge_wait();
    check("t6 idle at zero", int'(p_busy), 0);
    check("t6 duty zero", int'(p_duty), 0);
    stop = 1'b0;
    drive(0,1,0,0,8'd0);
    check("t6 ready after stop", int'(p_ready), 1);
    edge_wait();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
